// File: rtl/h264_pkg.sv
// h264_pkg: shared widths, packed pixel/residual word types and the per-lane
// residual subtraction used by the h264residual forward path.
package h264_pkg;

  localparam int PIX_W = 8;
  localparam int RES_W = 9;
  localparam int LANES = 4;

  typedef logic [LANES*PIX_W-1:0] pix4_t;
  typedef logic [LANES*RES_W-1:0] res4_t;

  // Both operands are zero-extended to 9 bits, so the difference always fits
  // in -255..+255 and never needs clipping.
  function automatic logic signed [RES_W-1:0] pix_sub(input logic [PIX_W-1:0] cur,
                                                      input logic [PIX_W-1:0] base);
    logic signed [RES_W-1:0] c;
    logic signed [RES_W-1:0] b;
    c = $signed({1'b0, cur});
    b = $signed({1'b0, base});
    return c - b;
  endfunction

endpackage

// File: rtl/h264residual_fifo.sv
// h264residual_fifo: synchronous FIFO holding {chroma, base} prediction entries.
//   CLK2, RESET      clock, asynchronous active-high reset
//   flush            synchronous clear of pointers and count
//   push, wdata      write request and entry
//   pop, rdata       read request; rdata shows the head entry combinationally
//   count            occupancy, 0..DEPTH
//   full, empty      occupancy flags
//   ovf, udf         single-cycle pulses: push dropped / pop on empty
module h264residual_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 33
) (
  input  logic                       CLK2,
  input  logic                       RESET,
  input  logic                       flush,
  input  logic                       push,
  input  logic [W-1:0]               wdata,
  input  logic                       pop,
  output logic [W-1:0]               rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic                       ovf,
  output logic                       udf
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));

  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign do_pop  = pop  & ~flush & ~empty;
  assign do_push = push & ~flush & (~full | do_pop);
  assign ovf     = push & ~flush & full & ~do_pop;
  assign udf     = pop  & ~flush & empty;

  assign rdata = mem[rd_ptr];

  always_ff @(posedge CLK2 or posedge RESET) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK2) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/h264residual.sv
// h264residual: buffers prediction words, subtracts them from current-pixel
// words and emits 4x9-bit residuals with the matching base forwarded alongside.
//   CLK2, RESET                  clock, asynchronous active-high reset
//   NEWSLICE                     synchronous flush at slice start (ERR kept)
//   BSTROBEI, BCHROMAI, BASEI    prediction word in
//   STROBEI, CHROMAI, DATAI      current-pixel word in, pops one base
//   READY                        room for a full quad in the base FIFO
//   STROBEO / CSTROBEO, DATAO    luma / chroma residual out (latency 2)
//   BSTROBEO, BCHROMAO, BASEO    forwarded base aligned with DATAO
//   ERR                          sticky protocol error
module h264residual
  import h264_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic        CLK2,
  input  logic        RESET,
  input  logic        NEWSLICE,
  input  logic        BSTROBEI,
  input  logic        BCHROMAI,
  input  logic [31:0] BASEI,
  input  logic        STROBEI,
  input  logic        CHROMAI,
  input  logic [31:0] DATAI,
  output logic        READY,
  output logic        STROBEO,
  output logic        CSTROBEO,
  output logic [35:0] DATAO,
  output logic        BSTROBEO,
  output logic        BCHROMAO,
  output logic [31:0] BASEO,
  output logic        ERR
);

  localparam int AW = $clog2(DEPTH);

  logic          push_p0;
  logic          pop_p0;
  logic          pop_do_p0;
  logic          push_acc_p0;
  logic [32:0]   head_p0;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          ovf;
  logic          udf;
  pix4_t         base_p0;
  logic          chroma_p0;
  logic          mismatch_p0;
  res4_t         diff_p0;

  logic          vld_p1;
  logic          chroma_p1;
  res4_t         diff_p1;
  pix4_t         base_p1;

  logic [1:0]    push_run;
  logic [1:0]    pop_run;
  logic          bstb_q;
  logic          stb_q;
  logic          align_err;

  // Strobes arriving together with NEWSLICE belong to the old slice and are ignored.
  assign push_p0 = BSTROBEI & ~NEWSLICE;
  assign pop_p0  = STROBEI  & ~NEWSLICE;

  h264residual_fifo #(
    .DEPTH (DEPTH),
    .W     (33)
  ) u_fifo (
    .CLK2  (CLK2),
    .RESET (RESET),
    .flush (NEWSLICE),
    .push  (push_p0),
    .wdata ({BCHROMAI, BASEI}),
    .pop   (pop_p0),
    .rdata (head_p0),
    .count (count),
    .full  (full),
    .empty (empty),
    .ovf   (ovf),
    .udf   (udf)
  );

  assign READY       = (count <= (AW+1)'(DEPTH-4));
  assign pop_do_p0   = pop_p0 & ~empty;
  assign push_acc_p0 = push_p0 & (~full | pop_do_p0);

  // On underflow the base is zero and the chroma tag comes from the current word;
  // a same-cycle push into an empty FIFO is deliberately not bypassed.
  assign base_p0     = empty ? '0 : head_p0[31:0];
  assign chroma_p0   = empty ? CHROMAI : head_p0[32];
  assign mismatch_p0 = pop_do_p0 & (CHROMAI != head_p0[32]);

  always_comb begin
    diff_p0 = '0;
    for (int k = 0; k < LANES; k++) begin
      diff_p0[k*RES_W +: RES_W] = pix_sub(DATAI[k*PIX_W +: PIX_W], base_p0[k*PIX_W +: PIX_W]);
    end
  end

  // ---- stage p0 -> p1: lane differences, base and chroma registered ----
  always_ff @(posedge CLK2 or posedge RESET) begin
    if (RESET) begin
      vld_p1    <= 1'b0;
      chroma_p1 <= 1'b0;
    end else begin
      vld_p1    <= pop_p0;
      chroma_p1 <= chroma_p0;
    end
  end

  always_ff @(posedge CLK2) begin
    if (pop_p0) begin
      diff_p1 <= diff_p0;
      base_p1 <= base_p0;
    end
  end

  // ---- stage p1 -> p2: steered outputs ----
  always_ff @(posedge CLK2 or posedge RESET) begin
    if (RESET) begin
      STROBEO  <= 1'b0;
      CSTROBEO <= 1'b0;
      BCHROMAO <= 1'b0;
      DATAO    <= '0;
      BASEO    <= '0;
    end else begin
      STROBEO  <= vld_p1 & ~chroma_p1 & ~NEWSLICE;
      CSTROBEO <= vld_p1 &  chroma_p1 & ~NEWSLICE;
      if (vld_p1 & ~NEWSLICE) begin
        BCHROMAO <= chroma_p1;
        DATAO    <= diff_p1;
        BASEO    <= base_p1;
      end
    end
  end

  assign BSTROBEO = STROBEO | CSTROBEO;

  // Quad alignment: a strobe run must end on a multiple of four transfers.
  always_ff @(posedge CLK2 or posedge RESET) begin
    if (RESET) begin
      push_run <= '0;
      pop_run  <= '0;
      bstb_q   <= 1'b0;
      stb_q    <= 1'b0;
    end else if (NEWSLICE) begin
      push_run <= '0;
      pop_run  <= '0;
      bstb_q   <= 1'b0;
      stb_q    <= 1'b0;
    end else begin
      bstb_q <= BSTROBEI;
      stb_q  <= STROBEI;
      if (push_acc_p0) push_run <= push_run + 1'b1;
      if (pop_do_p0)   pop_run  <= pop_run + 1'b1;
    end
  end

  assign align_err = ~NEWSLICE &
                     ((bstb_q & ~BSTROBEI & (push_run != 2'd0)) |
                      (stb_q  & ~STROBEI  & (pop_run  != 2'd0)));

  always_ff @(posedge CLK2 or posedge RESET) begin
    if (RESET) begin
      ERR <= 1'b0;
    end else if (ovf | udf | mismatch_p0 | align_err) begin
      ERR <= 1'b1;
    end
  end

endmodule

// File: tb/tb_h264residual.sv
module tb_h264residual;

  localparam int DEPTH = 16;

  logic        CLK2 = 1'b0;
  logic        RESET;
  logic        NEWSLICE;
  logic        BSTROBEI;
  logic        BCHROMAI;
  logic [31:0] BASEI;
  logic        STROBEI;
  logic        CHROMAI;
  logic [31:0] DATAI;
  logic        READY;
  logic        STROBEO;
  logic        CSTROBEO;
  logic [35:0] DATAO;
  logic        BSTROBEO;
  logic        BCHROMAO;
  logic [31:0] BASEO;
  logic        ERR;

  int total  = 0;
  int passed = 0;

  // push stimulus, pop stimulus and expected outputs per popped word
  logic [31:0] bq [16];
  logic        bc [16];
  logic [31:0] cq [16];
  logic        cc [16];
  logic [35:0] ed [16];
  logic [31:0] eb [16];
  logic        ec [16];

  h264residual #(.DEPTH(DEPTH)) dut (
    .CLK2     (CLK2),
    .RESET    (RESET),
    .NEWSLICE (NEWSLICE),
    .BSTROBEI (BSTROBEI),
    .BCHROMAI (BCHROMAI),
    .BASEI    (BASEI),
    .STROBEI  (STROBEI),
    .CHROMAI  (CHROMAI),
    .DATAI    (DATAI),
    .READY    (READY),
    .STROBEO  (STROBEO),
    .CSTROBEO (CSTROBEO),
    .DATAO    (DATAO),
    .BSTROBEO (BSTROBEO),
    .BCHROMAO (BCHROMAO),
    .BASEO    (BASEO),
    .ERR      (ERR)
  );

  always #5 CLK2 = ~CLK2;

  // Independent lane model: plain integer subtraction, low 9 bits kept.
  function automatic logic [35:0] model(input logic [31:0] c, input logic [31:0] b);
    logic [35:0] r;
    int d;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      d = int'(c[8*k +: 8]) - int'(b[8*k +: 8]);
      r[9*k +: 9] = d[8:0];
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK2);
    #1;
  endtask

  task automatic idle_inputs();
    NEWSLICE = 1'b0;
    BSTROBEI = 1'b0; BCHROMAI = 1'b0; BASEI = '0;
    STROBEI  = 1'b0; CHROMAI  = 1'b0; DATAI = '0;
  endtask

  task automatic reset_dut();
    idle_inputs();
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    step();
  endtask

  // np pushes from bq/bc and nq pops from cq/cc, both starting in the same cycle;
  // popped word j is checked two edges after it was presented.
  task automatic run(input string name, input int np, input int nq, input bit rchk);
    int n;
    n = (np > nq) ? np : nq;
    for (int i = 0; i <= n; i++) begin
      BSTROBEI = (i < np);
      BCHROMAI = (i < np) ? bc[i] : 1'b0;
      BASEI    = (i < np) ? bq[i] : 32'h0;
      STROBEI  = (i < nq);
      CHROMAI  = (i < nq) ? cc[i] : 1'b0;
      DATAI    = (i < nq) ? cq[i] : 32'h0;
      step();
      if (rchk && i < np)
        chk($sformatf("%s.ready%0d", name, i), 72'(READY), 72'((i + 1) <= DEPTH - 4));
      if (i >= 1 && i <= nq)
        chk($sformatf("%s.word%0d", name, i - 1),
            {BSTROBEO, STROBEO, CSTROBEO, BCHROMAO, BASEO, DATAO},
            {1'b1, ~ec[i-1], ec[i-1], ec[i-1], eb[i-1], ed[i-1]});
    end
  endtask

  initial begin
    idle_inputs();
    RESET = 1'b1;
    #1;
    chk("rst.outs", {BSTROBEO, STROBEO, CSTROBEO, BCHROMAO, BASEO, DATAO}, 72'h0);
    chk("rst.ready_err", {READY, ERR}, 72'b10);
    step();
    RESET = 1'b0;
    step();

    // 1: basic luma quad
    for (int i = 0; i < 4; i++) begin
      bq[i] = 32'h80808080; bc[i] = 1'b0;
      cq[i] = 32'h00FF0081; cc[i] = 1'b0;
      ed[i] = {9'h180, 9'h07F, 9'h180, 9'h001}; eb[i] = 32'h80808080; ec[i] = 1'b0;
    end
    run("t1push", 4, 0, 0);
    run("t1pop", 0, 4, 0);
    step();
    chk("t1.idle", {BSTROBEO, STROBEO, CSTROBEO, ERR}, 72'h0);
    chk("t1.hold", 72'(DATAO), 72'({9'h180, 9'h07F, 9'h180, 9'h001}));

    // 2: extreme residuals
    for (int i = 0; i < 4; i++) begin
      bq[i] = 32'hFF00FF00; cq[i] = 32'h00FF00FF;
      ed[i] = {9'h101, 9'h0FF, 9'h101, 9'h0FF}; eb[i] = 32'hFF00FF00;
    end
    run("t2push", 4, 0, 0);
    run("t2pop", 0, 4, 0);
    chk("t2.err", 72'(ERR), 72'h0);

    // 3: luma quad then chroma quad, steering by FIFO flag
    for (int i = 0; i < 8; i++) begin
      bc[i] = (i >= 4);
      bq[i] = (i >= 4) ? 32'h20202020 : 32'h10101010;
      cq[i] = 32'h30303030; cc[i] = (i >= 4);
      ed[i] = (i >= 4) ? {4{9'h010}} : {4{9'h020}};
      eb[i] = bq[i]; ec[i] = bc[i];
    end
    run("t3push", 8, 0, 0);
    run("t3pop", 0, 8, 0);
    chk("t3.err0", 72'(ERR), 72'h0);
    cc[5] = 1'b0;
    run("t3push2", 8, 0, 0);
    run("t3pop2", 0, 8, 0);
    chk("t3.mismatch", 72'(ERR), 72'h1);

    // 4: fill, push+pop at full, overflow, ordered drain
    reset_dut();
    for (int i = 0; i < 16; i++) begin
      bq[i] = 32'h01010101 * (i + 1); bc[i] = 1'b0;
      cq[i] = 32'h80808080; cc[i] = 1'b0;
      ed[i] = model(32'h80808080, bq[i]); eb[i] = bq[i]; ec[i] = 1'b0;
    end
    run("t4fill", 16, 0, 1);
    chk("t4.full_err", {READY, ERR}, 72'b00);
    for (int i = 0; i < 4; i++) bq[i] = 32'h01010101 * (i + 33);
    run("t4pp", 4, 4, 0);
    chk("t4.pp", {READY, ERR}, 72'b00);
    BSTROBEI = 1'b1; BASEI = 32'hDEADBEEF;
    step();
    idle_inputs();
    step();
    chk("t4.ovf", {READY, ERR}, 72'b01);
    for (int i = 0; i < 16; i++) begin
      eb[i] = (i < 12) ? 32'h01010101 * (i + 5) : 32'h01010101 * (i + 21);
      ed[i] = model(32'h80808080, eb[i]);
    end
    run("t4drain", 0, 16, 0);
    chk("t4.ready", 72'(READY), 72'h1);

    // 5: underflow
    reset_dut();
    cq[0] = 32'h01020304; cc[0] = 1'b0;
    ed[0] = {9'h001, 9'h002, 9'h003, 9'h004}; eb[0] = 32'h0; ec[0] = 1'b0;
    run("t5", 0, 1, 0);
    chk("t5.err", 72'(ERR), 72'h1);

    // 6: NEWSLICE flush mid-burst, then async reset mid-burst
    reset_dut();
    for (int i = 0; i < 4; i++) begin bq[i] = 32'h40404040; bc[i] = 1'b0; end
    run("t6push", 4, 0, 0);
    STROBEI = 1'b1; DATAI = 32'h50505050;
    step();
    NEWSLICE = 1'b1;
    step();
    idle_inputs();
    chk("t6.ns0", {BSTROBEO, STROBEO, CSTROBEO}, 72'h0);
    step();
    chk("t6.ns1", {BSTROBEO, STROBEO, CSTROBEO}, 72'h0);
    step();
    chk("t6.ns2", {BSTROBEO, STROBEO, CSTROBEO, READY, ERR}, 72'b00010);
    for (int i = 0; i < 4; i++) begin
      bq[i] = 32'h11111111; cq[i] = 32'h22222222; cc[i] = 1'b0;
      ed[i] = {4{9'h011}}; eb[i] = 32'h11111111; ec[i] = 1'b0;
    end
    run("t6fpush", 4, 0, 0);
    run("t6fpop", 0, 4, 0);
    chk("t6.err", 72'(ERR), 72'h0);
    for (int i = 0; i < 4; i++) bq[i] = 32'h01010101;
    run("t6rpush", 4, 0, 0);
    STROBEI = 1'b1; DATAI = 32'h03030303;
    step();
    step();
    chk("t6.pre", {STROBEO, DATAO}, {1'b1, {4{9'h002}}});
    #2;
    RESET = 1'b1;
    #1;
    chk("t6.async", {BSTROBEO, STROBEO, CSTROBEO, BCHROMAO, BASEO, DATAO}, 72'h0);
    chk("t6.async_re", {READY, ERR}, 72'b10);
    idle_inputs();
    #1;
    RESET = 1'b0;
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
